// File: rtl/issue_queue_pkg.sv
// issue_queue_pkg: shared issue-queue and dispatch types and sizing constants
package issue_queue_pkg;
  localparam int WRITE_NUM      = 2;
  localparam int WAKE_NUM       = 3;
  localparam int ISSUE_WIDTH    = 2;
  localparam int ENTRY_TYPE_NUM = 4;
  localparam int DISPATCH_DEPTH = 4;
  typedef logic [31:0] word_t;
  typedef logic [5:0]  tag_t;
  typedef enum logic [1:0] {ET_ALU, ET_MEM, ET_BRU, ET_MDU} entry_type_t;
  typedef struct packed {
    logic  valid;
    tag_t  id;
    word_t data;
  } src_t;
  typedef struct packed {
    logic        valid;
    entry_type_t entry_type;
    tag_t        dst;
    src_t        src1;
    src_t        src2;
  } write_req_t;
  typedef write_req_t entry_t;
  typedef struct packed {
    logic valid;
    tag_t id;
  } wake_req_t;
endpackage

// File: rtl/dispatch_wake.sv
// dispatch_wake: applies all wakeup tags (and broadcast data where present) to one entry
module dispatch_wake
  import issue_queue_pkg::*;
(
  input  entry_t    e,
  input  wake_req_t wake [WAKE_NUM],
  input  word_t     broadcast [ISSUE_WIDTH],
  output entry_t    o
);
  word_t               bc [WAKE_NUM];
  logic [WAKE_NUM-1:0] has_data;
  // only the first ISSUE_WIDTH wakes carry result data
  for (genvar g = 0; g < WAKE_NUM; g++) begin : g_bc
    if (g < ISSUE_WIDTH) begin : g_d
      assign bc[g]       = broadcast[g];
      assign has_data[g] = 1'b1;
    end else begin : g_n
      assign bc[g]       = '0;
      assign has_data[g] = 1'b0;
    end
  end
  always_comb begin
    o = e;
    for (int i = 0; i < WAKE_NUM; i++) begin
      if (wake[i].valid && wake[i].id == e.src1.id) begin
        o.src1.valid = 1'b1;
        if (has_data[i]) o.src1.data = bc[i];
      end
      if (wake[i].valid && wake[i].id == e.src2.id) begin
        o.src2.valid = 1'b1;
        if (has_data[i]) o.src2.data = bc[i];
      end
    end
  end
endmodule

// File: rtl/dispatch_buffer.sv
// dispatch_buffer: circular FIFO between rename and the issue queues with in-place wakeup
module dispatch_buffer
  import issue_queue_pkg::*;
#(
  parameter int DEPTH = DISPATCH_DEPTH
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      flush,
  input  write_req_t                in [WRITE_NUM],
  output logic                      in_ready,
  output write_req_t                write [WRITE_NUM],
  input  logic [ENTRY_TYPE_NUM-1:0] queue_full,
  input  wake_req_t                 wake [WAKE_NUM],
  input  word_t                     broadcast [ISSUE_WIDTH]
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  entry_t               mem [DEPTH];
  entry_t               mem_w [DEPTH];
  entry_t               in_w [WRITE_NUM];
  logic [DEPTH-1:0]     done;
  logic [PW-1:0]        head, tail;
  logic [CW-1:0]        count, n_ret, n_push;
  logic [PW-1:0]        idx [WRITE_NUM];
  logic [PW-1:0]        pos [WRITE_NUM];
  logic [WRITE_NUM-1:0] acc;
  logic                 run;
  for (genvar g = 0; g < DEPTH; g++) begin : g_mem
    dispatch_wake u_wake (.e(mem[g]), .wake(wake), .broadcast(broadcast), .o(mem_w[g]));
  end
  for (genvar g = 0; g < WRITE_NUM; g++) begin : g_in
    dispatch_wake u_wake (.e(in[g]), .wake(wake), .broadcast(broadcast), .o(in_w[g]));
  end
  assign in_ready = count <= CW'(DEPTH - WRITE_NUM);
  // retirement stops at the first presented entry that is neither done nor accepted
  always_comb begin
    run    = 1'b1;
    n_ret  = '0;
    n_push = '0;
    for (int k = 0; k < WRITE_NUM; k++) begin
      idx[k]   = head + PW'(k);
      write[k] = (CW'(k) < count && !done[idx[k]]) ? mem[idx[k]] : '0;
      acc[k]   = write[k].valid && !queue_full[write[k].entry_type];
      run      = run && CW'(k) < count && (done[idx[k]] || acc[k]);
      n_ret    = n_ret + CW'(run);
      pos[k]   = tail + PW'(n_push);
      n_push   = n_push + CW'(in_ready && in[k].valid);
    end
  end
  always_ff @(posedge clk) begin
    if (!resetn) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      done  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= mem_w[i];
      if (flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
        done  <= '0;
      end else begin
        for (int k = 0; k < WRITE_NUM; k++) begin
          if (acc[k]) done[idx[k]] <= 1'b1;
          if (CW'(k) < n_ret) done[idx[k]] <= 1'b0;
          if (in_ready && in[k].valid) begin
            mem[pos[k]]  <= in_w[k];
            done[pos[k]] <= 1'b0;
          end
        end
        head  <= head + PW'(n_ret);
        tail  <= tail + PW'(n_push);
        count <= count + n_push - n_ret;
      end
    end
  end
endmodule

// File: tb/tb_dispatch_buffer.sv
// tb_dispatch_buffer: queue-based reference model, directed scenarios and random traffic
module tb_dispatch_buffer;
  import issue_queue_pkg::*;
  localparam int DEPTH = 4;
  logic                      clk = 1'b0;
  logic                      resetn = 1'b0;
  logic                      flush = 1'b0;
  write_req_t                in [WRITE_NUM];
  logic                      in_ready;
  write_req_t                write [WRITE_NUM];
  logic [ENTRY_TYPE_NUM-1:0] queue_full;
  wake_req_t                 wake [WAKE_NUM];
  word_t                     broadcast [ISSUE_WIDTH];
  int total = 0;
  int bad = 0;
  typedef struct {
    entry_t e;
    bit     done;
  } ment_t;
  ment_t mq[$];

  always #5 clk = ~clk;

  dispatch_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn), .flush(flush), .in(in), .in_ready(in_ready),
    .write(write), .queue_full(queue_full), .wake(wake), .broadcast(broadcast)
  );

  task automatic chk(string nm, logic [127:0] a, logic [127:0] x);
    total++;
    if (a !== x) begin
      bad++;
      $display("FAIL %s got=%h want=%h at %0t", nm, a, x, $time);
    end
  endtask

  function automatic entry_t apply_wake(entry_t e);
    word_t bc [WAKE_NUM];
    entry_t r = e;
    for (int i = 0; i < WAKE_NUM; i++) bc[i] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) bc[i] = broadcast[i];
    for (int i = 0; i < WAKE_NUM; i++) begin
      if (wake[i].valid && wake[i].id == e.src1.id) begin
        r.src1.valid = 1'b1;
        if (i < ISSUE_WIDTH) r.src1.data = bc[i];
      end
      if (wake[i].valid && wake[i].id == e.src2.id) begin
        r.src2.valid = 1'b1;
        if (i < ISSUE_WIDTH) r.src2.data = bc[i];
      end
    end
    return r;
  endfunction

  function automatic write_req_t mk(entry_type_t t, int dst, int s1, bit s1v);
    write_req_t r = '0;
    r.valid      = 1'b1;
    r.entry_type = t;
    r.dst        = tag_t'(dst);
    r.src1.id    = tag_t'(s1);
    r.src1.valid = s1v;
    return r;
  endfunction

  task automatic idle();
    flush      = 1'b0;
    queue_full = '0;
    for (int k = 0; k < WRITE_NUM; k++) in[k] = '0;
    for (int i = 0; i < WAKE_NUM; i++) wake[i] = '0;
    for (int i = 0; i < ISSUE_WIDTH; i++) broadcast[i] = '0;
  endtask

  task automatic rand_inputs();
    resetn = $urandom_range(0, 199) != 0;
    flush  = $urandom_range(0, 39) == 0;
    for (int b = 0; b < ENTRY_TYPE_NUM; b++) queue_full[b] = $urandom_range(0, 9) < 3;
    for (int k = 0; k < WRITE_NUM; k++) begin
      in[k] = '0;
      if ($urandom_range(0, 9) < 7) begin
        in[k] = mk(entry_type_t'($urandom_range(0, 3)), int'($urandom_range(0, 63)),
                   int'($urandom_range(0, 7)), $urandom_range(0, 1) == 1);
        in[k].src2.id    = tag_t'($urandom_range(0, 7));
        in[k].src2.valid = $urandom_range(0, 1) == 1;
      end
    end
    for (int i = 0; i < WAKE_NUM; i++) begin
      wake[i].valid = $urandom_range(0, 1) == 1;
      wake[i].id    = tag_t'($urandom_range(0, 7));
    end
    for (int i = 0; i < ISSUE_WIDTH; i++) broadcast[i] = $urandom;
  endtask

  // compare outputs against the model, then advance the model across the next rising edge
  task automatic tick();
    write_req_t ex [WRITE_NUM];
    bit rdy;
    int n;
    n   = mq.size();
    rdy = (DEPTH - n) >= WRITE_NUM;
    for (int k = 0; k < WRITE_NUM; k++) ex[k] = (k < n && !mq[k].done) ? mq[k].e : '0;
    #1;
    chk("in_ready", 128'(in_ready), 128'(rdy));
    for (int k = 0; k < WRITE_NUM; k++) chk($sformatf("write%0d", k), 128'(write[k]), 128'(ex[k]));
    if (!resetn || flush) mq.delete();
    else begin
      for (int k = 0; k < WRITE_NUM; k++)
        if (ex[k].valid && !queue_full[ex[k].entry_type]) mq[k].done = 1'b1;
      foreach (mq[i]) mq[i].e = apply_wake(mq[i].e);
      while (mq.size() > 0 && mq[0].done) void'(mq.pop_front());
      if (rdy)
        for (int k = 0; k < WRITE_NUM; k++)
          if (in[k].valid) mq.push_back('{apply_wake(in[k]), 1'b0});
    end
    @(negedge clk);
  endtask

  initial begin
    idle();
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("rst_in_ready", 128'(in_ready), 128'(1));
    chk("rst_write0", 128'(write[0]), 128'(0));
    chk("rst_write1", 128'(write[1]), 128'(0));
    // simple pass
    in[0] = mk(ET_ALU, 1, 0, 0);
    in[1] = mk(ET_MEM, 2, 0, 0);
    tick();
    idle();
    chk("pass_w0_valid", 128'(write[0].valid), 128'(1));
    chk("pass_w0_dst", 128'(write[0].dst), 128'(1));
    chk("pass_w1_dst", 128'(write[1].dst), 128'(2));
    chk("pass_w1_type", 128'(write[1].entry_type), 128'(ET_MEM));
    tick();
    chk("pass_empty", 128'(write[0].valid), 128'(0));
    // partial reject
    in[0] = mk(ET_ALU, 3, 0, 0);
    in[1] = mk(ET_MEM, 4, 0, 0);
    tick();
    idle();
    queue_full[ET_ALU] = 1'b1;
    tick();
    chk("rej_w0_valid", 128'(write[0].valid), 128'(1));
    chk("rej_w0_dst", 128'(write[0].dst), 128'(3));
    chk("rej_w1_done", 128'(write[1].valid), 128'(0));
    queue_full = '0;
    tick();
    chk("rej_empty", 128'(write[0].valid), 128'(0));
    // fill then release
    queue_full = '1;
    in[0] = mk(ET_ALU, 5, 0, 0);
    in[1] = mk(ET_MEM, 6, 0, 0);
    tick();
    in[0] = mk(ET_ALU, 7, 0, 0);
    in[1] = mk(ET_MEM, 8, 0, 0);
    tick();
    idle();
    queue_full = '1;
    chk("fill_not_ready", 128'(in_ready), 128'(0));
    chk("fill_w0_dst", 128'(write[0].dst), 128'(5));
    chk("fill_w1_dst", 128'(write[1].dst), 128'(6));
    queue_full = '0;
    tick();
    chk("fill_half_w0_dst", 128'(write[0].dst), 128'(7));
    chk("fill_half_ready", 128'(in_ready), 128'(1));
    tick();
    chk("fill_drained", 128'(write[0].valid), 128'(0));
    // wake while buffered
    queue_full = '1;
    in[0] = mk(ET_ALU, 9, 7, 0);
    tick();
    idle();
    queue_full   = '1;
    wake[0]      = '{1'b1, 6'd7};
    broadcast[0] = 32'hDEADBEEF;
    tick();
    idle();
    queue_full = '1;
    chk("wake_src1_valid", 128'(write[0].src1.valid), 128'(1));
    chk("wake_src1_data", 128'(write[0].src1.data), 128'(32'hDEADBEEF));
    // flush with a push in the same cycle
    in[0] = mk(ET_ALU, 10, 0, 0);
    in[1] = mk(ET_MEM, 11, 0, 0);
    tick();
    idle();
    queue_full = '1;
    flush = 1'b1;
    in[0] = mk(ET_ALU, 12, 0, 0);
    in[1] = mk(ET_MEM, 13, 0, 0);
    tick();
    idle();
    chk("flush_w0", 128'(write[0].valid), 128'(0));
    chk("flush_w1", 128'(write[1].valid), 128'(0));
    chk("flush_ready", 128'(in_ready), 128'(1));
    // streaming across pointer wrap
    for (int p = 0; p < 6; p++) begin
      in[0] = mk(ET_ALU, 20 + 2 * p, 0, 0);
      in[1] = mk(ET_MEM, 21 + 2 * p, 0, 0);
      tick();
      chk($sformatf("wrap%0d_w0", p), 128'(write[0].dst), 128'(20 + 2 * p));
      chk($sformatf("wrap%0d_w1", p), 128'(write[1].dst), 128'(21 + 2 * p));
    end
    idle();
    tick();
    repeat (3000) begin
      rand_inputs();
      tick();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
